// File: rtl/dac3162_stream_ctrl.sv
// Sample-pair FIFO plus IDLE/WAKE/PRIME/RUN sequencer that feeds the DAC3162 channel drivers.
// Optional saturating underflow counter is built when DAC3162_UNDERFLOW_CNT_EN is defined.
module dac3162_stream_ctrl #(
  parameter int FIFO_DEPTH  = 16,
  parameter int WAKE_CYCLES = 64
) (
  input  logic        clk_in,
  input  logic        rst,
  input  logic        enable,
  input  logic [23:0] s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [11:0] DA3162_CH1,
  output logic [11:0] DA3162_CH2,
  output logic        dac_active,
  output logic [1:0]  state,
  output logic        underflow,
  output logic [15:0] underflow_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int WW = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;
  localparam logic [AW:0]   FULL_CNT  = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]   HALF_CNT  = (AW+1)'(FIFO_DEPTH / 2);
  localparam logic [WW-1:0] WAKE_LAST = WW'(WAKE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAKE  = 2'd1,
    ST_PRIME = 2'd2,
    ST_RUN   = 2'd3
  } state_t;

  state_t        state_r;
  logic [WW-1:0] wake_cnt_r;
  logic [AW:0]   wr_ptr_r;
  logic [AW:0]   rd_ptr_r;
  logic [23:0]   mem_r [FIFO_DEPTH];
  logic [11:0]   ch1_r;
  logic [11:0]   ch2_r;
  logic          underflow_r;

  logic [AW:0]   count_s;
  logic          full_s;
  logic          empty_s;
  logic          push_s;
  logic          uf_event_s;

  assign count_s    = wr_ptr_r - rd_ptr_r;
  assign full_s     = (count_s == FULL_CNT);
  assign empty_s    = (wr_ptr_r == rd_ptr_r);
  assign s_ready    = (state_r != ST_IDLE) && !full_s;
  assign push_s     = s_valid && s_ready;
  // Pop decision uses pre-edge occupancy, so a same-cycle push into an empty FIFO still underflows.
  assign uf_event_s = enable && (state_r == ST_RUN) && empty_s;

  assign state      = state_r;
  assign dac_active = (state_r != ST_IDLE);
  assign DA3162_CH1 = ch1_r;
  assign DA3162_CH2 = ch2_r;
  assign underflow  = underflow_r;

  // Sample storage, written on every accepted pair while streaming is enabled.
  always_ff @(posedge clk_in) begin
    if (push_s && enable) begin
      mem_r[wr_ptr_r[AW-1:0]] <= s_data;
    end
  end

  // Sequencer, FIFO pointers and registered DAC outputs.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      wake_cnt_r  <= '0;
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      ch1_r       <= 12'h000;
      ch2_r       <= 12'h000;
      underflow_r <= 1'b0;
    end else if (!enable) begin
      state_r     <= ST_IDLE;
      wake_cnt_r  <= '0;
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      ch1_r       <= 12'h000;
      ch2_r       <= 12'h000;
      underflow_r <= 1'b0;
    end else begin
      underflow_r <= uf_event_s;
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      case (state_r)
        ST_IDLE: begin
          state_r    <= ST_WAKE;
          wake_cnt_r <= '0;
        end
        ST_WAKE: begin
          if (wake_cnt_r == WAKE_LAST) begin
            state_r <= ST_PRIME;
          end else begin
            wake_cnt_r <= wake_cnt_r + WW'(1);
          end
        end
        ST_PRIME: begin
          if (count_s >= HALF_CNT) begin
            state_r <= ST_RUN;
          end else begin
            state_r <= ST_PRIME;
          end
        end
        ST_RUN: begin
          if (!empty_s) begin
            {ch1_r, ch2_r} <= mem_r[rd_ptr_r[AW-1:0]];
            rd_ptr_r       <= rd_ptr_r + (AW+1)'(1);
          end else begin
            rd_ptr_r <= rd_ptr_r;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

`ifdef DAC3162_UNDERFLOW_CNT_EN
  logic [15:0] uf_cnt_r;

  // Saturating underflow tally; only rst clears it, stopping the stream does not.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      uf_cnt_r <= 16'h0000;
    end else if (uf_event_s && (uf_cnt_r != 16'hFFFF)) begin
      uf_cnt_r <= uf_cnt_r + 16'h0001;
    end else begin
      uf_cnt_r <= uf_cnt_r;
    end
  end

  assign underflow_cnt = uf_cnt_r;
`else
  assign underflow_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_dac3162_stream_ctrl.sv
// Directed bench for dac3162_stream_ctrl: a queue-based reference model tracks expected
// FIFO contents and outputs; every cycle and each scenario milestone is checked by assertion.
module tb_dac3162_stream_ctrl;

  logic        clk_in = 1'b0;
  logic        rst;
  logic        enable;
  logic [23:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic [11:0] ch1;
  logic [11:0] ch2;
  logic        dac_active;
  logic [1:0]  state;
  logic        underflow;
  logic [15:0] underflow_cnt;

  int total = 0;
  int bad   = 0;

  // reference model
  int          m_state;
  int          m_wake;
  logic [23:0] m_q[$];
  logic [11:0] m_o1;
  logic [11:0] m_o2;
  logic        m_uf;
  int          m_cnt;

  dac3162_stream_ctrl #(.FIFO_DEPTH(16), .WAKE_CYCLES(64)) dut (
    .clk_in        (clk_in),
    .rst           (rst),
    .enable        (enable),
    .s_data        (s_data),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .DA3162_CH1    (ch1),
    .DA3162_CH2    (ch2),
    .dac_active    (dac_active),
    .state         (state),
    .underflow     (underflow),
    .underflow_cnt (underflow_cnt)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_state = 0;
    m_wake  = 0;
    m_q.delete();
    m_o1    = 12'h000;
    m_o2    = 12'h000;
    m_uf    = 1'b0;
    m_cnt   = 0;
  endtask

  task automatic chk_all();
    chk("state", {22'd0, state}, 24'(m_state));
    chk("ch1", {12'd0, ch1}, {12'd0, m_o1});
    chk("ch2", {12'd0, ch2}, {12'd0, m_o2});
    chk("underflow", {23'd0, underflow}, {23'd0, m_uf});
    chk("s_ready", {23'd0, s_ready}, {23'd0, (m_state != 0) && (m_q.size() < 16)});
    chk("dac_active", {23'd0, dac_active}, {23'd0, m_state != 0});
    chk("underflow_cnt", {8'd0, underflow_cnt}, 24'(m_cnt));
  endtask

  // One clock: drive inputs, advance the model from pre-edge state, then check after the edge.
  task automatic cycle(input logic en, input logic vld, input logic [23:0] d, output logic pushed);
    int pre;
    logic [23:0] pair;
    enable  = en;
    s_valid = vld;
    s_data  = d;
    pre     = m_q.size();
    pushed  = vld && (m_state != 0) && (pre < 16) && en;
    m_uf    = 1'b0;
    if (!en) begin
      m_state = 0;
      m_wake  = 0;
      m_q.delete();
      m_o1    = 12'h000;
      m_o2    = 12'h000;
    end else begin
      case (m_state)
        0: begin m_state = 1; m_wake = 0; end
        1: begin
          if (m_wake == 63) m_state = 2;
          else m_wake++;
        end
        2: if (pre >= 8) m_state = 3;
        3: begin
          if (pre > 0) begin
            pair = m_q.pop_front();
            m_o1 = pair[23:12];
            m_o2 = pair[11:0];
          end else begin
            m_uf = 1'b1;
`ifdef DAC3162_UNDERFLOW_CNT_EN
            if (m_cnt < 65535) m_cnt++;
`endif
          end
        end
        default: m_state = 0;
      endcase
      if (pushed) m_q.push_back(d);
    end
    @(posedge clk_in);
    #1;
    chk_all();
  endtask

  initial begin
    logic p;
    int   idx;
    int   wake_seen;
    int   uf_seen;
    int   guard;
    logic [11:0] c1;
    logic [11:0] c2;

    rst = 1'b1; enable = 1'b0; s_valid = 1'b0; s_data = 24'h000000;
    m_reset();
    #1;
    chk_all();
    repeat (2) @(posedge clk_in);
    #1;
    rst = 1'b0;

    // startup + ordering ramp CH1=i, CH2=-i
    idx = 0; wake_seen = 0; uf_seen = 0; guard = 0;
    while (idx < 100 && guard < 400) begin
      c1 = 12'(idx);
      c2 = 12'(-idx);
      cycle(1'b1, 1'b1, {c1, c2}, p);
      if (state == 2'd1) wake_seen++;
      if (underflow) uf_seen++;
      if (m_q.size() == 16 && m_state == 1) chk("full_ready", {23'd0, s_ready}, 24'd0);
      if (p) idx++;
      guard++;
    end
    chk("wake_len", 24'(wake_seen), 24'd64);
    chk("ramp_pushed", 24'(idx), 24'd100);

    guard = 0;
    while (m_q.size() > 0 && guard < 40) begin
      cycle(1'b1, 1'b0, 24'h000000, p);
      if (underflow) uf_seen++;
      guard++;
    end
    chk("ramp_no_underflow", 24'(uf_seen), 24'd0);
    chk("ramp_last_ch1", {12'd0, ch1}, 24'd99);

    // underflow: 5 idle cycles in RUN with empty FIFO
    uf_seen = 0;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b0, 24'h000000, p);
      if (underflow) uf_seen++;
    end
    chk("uf_pulses", 24'(uf_seen), 24'd5);
    chk("uf_hold_ch1", {12'd0, ch1}, 24'd99);
    chk("uf_hold_ch2", {12'd0, ch2}, 24'h000F9D);
`ifdef DAC3162_UNDERFLOW_CNT_EN
    chk("uf_count", {8'd0, underflow_cnt}, 24'd5);
`else
    chk("uf_count", {8'd0, underflow_cnt}, 24'd0);
`endif

    // stop with occupancy 6 mid-RUN
    cycle(1'b0, 1'b0, 24'h000000, p);
    idx = 0; guard = 0;
    while (m_state != 3 && guard < 100) begin
      cycle(1'b1, idx < 8, {12'h500 + 12'(idx), 12'h700 + 12'(idx)}, p);
      if (p) idx++;
      guard++;
    end
    cycle(1'b1, 1'b0, 24'h000000, p);
    chk("first_out_ch1", {12'd0, ch1}, 24'h000500);
    chk("first_out_ch2", {12'd0, ch2}, 24'h000700);
    cycle(1'b1, 1'b0, 24'h000000, p);
    cycle(1'b0, 1'b0, 24'h000000, p);
    chk("stop_state", {22'd0, state}, 24'd0);
    chk("stop_ch1", {12'd0, ch1}, 24'd0);
    chk("stop_ready", {23'd0, s_ready}, 24'd0);

    // re-enable: flushed FIFO means new data comes out first
    idx = 0; guard = 0;
    while (m_state != 3 && guard < 100) begin
      cycle(1'b1, 1'b1, {12'h600 + 12'(idx), 12'h800 + 12'(idx)}, p);
      if (p) idx++;
      guard++;
    end
    cycle(1'b1, 1'b1, {12'h600 + 12'(idx), 12'h800 + 12'(idx)}, p);
    if (p) idx++;
    chk("reenable_first_ch1", {12'd0, ch1}, 24'h000600);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b1, {12'h600 + 12'(idx), 12'h800 + 12'(idx)}, p);
      if (p) idx++;
    end

    // async reset between edges
    #3;
    rst = 1'b1;
    #1;
    chk("arst_state", {22'd0, state}, 24'd0);
    chk("arst_ch1", {12'd0, ch1}, 24'd0);
    chk("arst_ch2", {12'd0, ch2}, 24'd0);
    chk("arst_ready", {23'd0, s_ready}, 24'd0);
    chk("arst_active", {23'd0, dac_active}, 24'd0);
    chk("arst_cnt", {8'd0, underflow_cnt}, 24'd0);
    m_reset();
    @(posedge clk_in);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 24'h000000, p);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dac3162_stream_ctrl.md
DAC3162_STREAM_CTRL -- requirements
Module: dac3162_stream_ctrl

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, sample-pair buffer depth (power of 2, 4..256).
REQ-002 SHALL have parameter WAKE_CYCLES, default 64, clk_in cycles spent in WAKE before priming.
REQ-003 SHALL have port clk_in, input, 1, single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port enable, input, 1, level; 1 = stream, 0 = stop and flush.
REQ-006 SHALL have port s_data, input, 24, sample pair {CH1[11:0], CH2[11:0]}, signed two's complement.
REQ-007 SHALL have port s_valid, input, 1, s_data valid.
REQ-008 SHALL have port s_ready, output, 1, block accepts s_data.
REQ-009 SHALL have port DA3162_CH1, output, 12, signed channel-1 sample to DAC driver.
REQ-010 SHALL have port DA3162_CH2, output, 12, signed channel-2 sample to DAC driver.
REQ-011 SHALL have port dac_active, output, 1, 1 in WAKE/PRIME/RUN; drives DAC wake logic.
REQ-012 SHALL have port state, output, 2, IDLE=0, WAKE=1, PRIME=2, RUN=3.
REQ-013 SHALL have port underflow, output, 1, one-cycle pulse per RUN cycle with empty FIFO.
REQ-014 SHALL have port underflow_cnt, output, 16, saturating underflow count (macro-dependent, REQ-032).

Function
REQ-015 SHALL accept a sample pair on any clk_in edge where s_valid=1 and s_ready=1.
REQ-016 SHALL drive s_ready = (state != IDLE) and FIFO not full; s_ready SHALL NOT depend combinationally on s_valid.
REQ-017 SHALL transition IDLE->WAKE on the first edge with enable=1.
REQ-018 SHALL remain in WAKE exactly WAKE_CYCLES cycles, then enter PRIME.
REQ-019 SHALL leave PRIME for RUN on the edge where FIFO occupancy >= FIFO_DEPTH/2.
REQ-020 SHALL pop one pair per cycle in RUN when FIFO non-empty; popped pair appears on DA3162_CH1/CH2 on the next edge (1-cycle latency).
REQ-021 SHALL, in RUN with FIFO empty, hold the previous output pair and assert underflow that cycle; RUN SHALL NOT be exited on underflow.
REQ-022 SHALL evaluate pop against pre-edge occupancy: a push into an empty FIFO in RUN still produces underflow that cycle, and the data is output one cycle later.
REQ-023 SHALL support simultaneous push and pop with occupancy unchanged; push blocked only when full (s_ready=0).
REQ-024 SHALL, on enable=0 in any state, enter IDLE on the next edge, flush the FIFO (occupancy 0), and drive both outputs to 12'h000 (mid-scale after the driver offset).
REQ-025 SHALL hold outputs at 12'h000 in IDLE, WAKE and PRIME.
REQ-026 SHALL wrap FIFO read/write pointers modulo FIFO_DEPTH, using an extra pointer bit for full/empty distinction.
REQ-027 SHALL restart WAKE counting from zero on each IDLE->WAKE entry.

Reset
REQ-028 SHALL on rst=1 asynchronously force: state=IDLE, FIFO empty, DA3162_CH1/CH2=0, s_ready=0, dac_active=0, underflow=0, underflow_cnt=0, WAKE counter=0.
REQ-029 SHALL treat rst asserted mid-RUN identically to power-up; no partial sample is emitted after release.
REQ-030 SHALL resume normal operation on the first edge after rst deassertion, evaluating enable at that edge.

Configuration
REQ-031 SHALL compile the underflow counter only when macro DAC3162_UNDERFLOW_CNT_EN is defined.
REQ-032 SHALL, with DAC3162_UNDERFLOW_CNT_EN defined, increment underflow_cnt per underflow pulse, saturate at 16'hFFFF, clear only on rst; without it, tie underflow_cnt to 16'h0000 (underflow pulse unaffected).

Verification
REQ-033 SHALL verify startup: enable=1, WAKE_CYCLES=64, continuous s_valid -> state 1 for 64 cycles, PRIME until occupancy 8, RUN; first output equals first pushed pair.
REQ-034 SHALL verify ordering: push ramp CH1=0..99, CH2=-CH1 at 1 pair/cycle -> outputs match in order, no underflow.
REQ-035 SHALL verify underflow: in RUN stop s_valid for 5 cycles after FIFO drains -> 5 underflow pulses, output holds last pair, underflow_cnt=5 with macro, 0 without.
REQ-036 SHALL verify full: hold s_valid in PRIME with FIFO_DEPTH=16 and RUN blocked by enable timing -> s_ready=0 at occupancy 16, no pair lost or duplicated.
REQ-037 SHALL verify stop: enable=0 mid-RUN with occupancy 6 -> next edge state=0, outputs 12'h000, s_ready=0, FIFO empty on re-enable.
REQ-038 SHALL verify async reset mid-RUN: rst pulsed between edges -> outputs 0 and state=0 immediately, before the next clk_in edge.
